// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
package seven_seg_pkg;

  typedef enum logic {
    DEADT = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam logic [3:0] BLANK_NIBBLE = 4'hF;
  localparam logic [3:0] AN_OFF       = 4'b1111;
  localparam logic [6:0] SEG_OFF      = 7'b1111111;
  localparam int         CNT_W        = 20;

  // True when any of the four BCD nibbles lies outside 0..9.
  function automatic logic has_invalid(input logic [15:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) begin
        r = 1'b1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_bcd.sv
// Active-low BCD to seven-segment decoder, segments ordered {a..g}.
module BCDtoSevenseg
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Segment pattern lookup; non-decimal codes leave the digit dark.
  always_comb begin
    o_seg = SEG_OFF;
    case (i_bcd)
      4'd0:    o_seg = 7'b0000001;
      4'd1:    o_seg = 7'b1001111;
      4'd2:    o_seg = 7'b0010010;
      4'd3:    o_seg = 7'b0000110;
      4'd4:    o_seg = 7'b1001100;
      4'd5:    o_seg = 7'b0100100;
      4'd6:    o_seg = 7'b0100000;
      4'd7:    o_seg = 7'b0001111;
      4'd8:    o_seg = 7'b0000000;
      4'd9:    o_seg = 7'b0000100;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scanner for a four-digit common-anode display with dead time,
// leading-zero blanking and frame-atomic double-buffered updates.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIV  = 50000,
  parameter int DEAD = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  bcd_out,
  output logic        invalid
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_dig;
  scan_state_t      r_state;
  scan_state_t      w_state_nxt;
  logic [15:0]      r_pend_val;
  logic [3:0]       r_pend_dp;
  logic [15:0]      r_disp_val;
  logic [3:0]       r_disp_dp;
  logic [3:0]       r_an;
  logic [3:0]       r_bcd;
  logic             r_dp;
  logic             r_invalid;
  logic             w_cnt_wrap;
  logic             w_frame_end;
  logic [15:0]      w_disp_val_nxt;
  logic [3:0]       w_disp_dp_nxt;
  logic [3:0]       w_nib;
  logic             w_blank;
  logic [3:0]       w_an_nxt;
  logic [3:0]       w_bcd_nxt;
  logic             w_dp_nxt;

  assign w_cnt_wrap  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_cnt_wrap & (r_dig == 2'd3);

  // Slot counter and digit index; the digit advances when the slot wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_dig <= 2'd0;
    end else if (w_cnt_wrap) begin
      r_cnt <= '0;
      r_dig <= r_dig + 2'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= DEADT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Scan FSM next state: dead time leads each slot, drive until the slot wraps.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DEADT: begin
        if (r_cnt == DEAD_LAST) begin
          w_state_nxt = DRIVE;
        end else begin
          w_state_nxt = DEADT;
        end
      end
      DRIVE: begin
        if (w_cnt_wrap) begin
          w_state_nxt = DEADT;
        end else begin
          w_state_nxt = DRIVE;
        end
      end
      default: w_state_nxt = DEADT;
    endcase
  end

  // A load coinciding with the frame boundary bypasses the pending buffer.
  always_comb begin
    w_disp_val_nxt = r_pend_val;
    w_disp_dp_nxt  = r_pend_dp;
    if (load) begin
      w_disp_val_nxt = value;
      w_disp_dp_nxt  = dp_in;
    end else begin
      w_disp_val_nxt = r_pend_val;
      w_disp_dp_nxt  = r_pend_dp;
    end
  end

  // Pending/display buffers and the per-frame invalid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_val <= 16'h0000;
      r_pend_dp  <= 4'b0000;
      r_disp_val <= 16'h0000;
      r_disp_dp  <= 4'b0000;
      r_invalid  <= 1'b0;
    end else begin
      if (load) begin
        r_pend_val <= value;
        r_pend_dp  <= dp_in;
      end
      if (w_frame_end) begin
        r_disp_val <= w_disp_val_nxt;
        r_disp_dp  <= w_disp_dp_nxt;
        r_invalid  <= has_invalid(w_disp_val_nxt);
      end
    end
  end

  assign w_nib = r_disp_val[{r_dig, 2'b00} +: 4];

  // Leading-zero blanking: a digit is dark when it and every digit above it are zero.
  always_comb begin
    w_blank = 1'b0;
    case (r_dig)
      2'd3:    w_blank = blank_lz & (r_disp_val[15:12] == 4'd0);
      2'd2:    w_blank = blank_lz & (r_disp_val[15:8] == 8'd0);
      2'd1:    w_blank = blank_lz & (r_disp_val[15:4] == 12'd0);
      default: w_blank = 1'b0;
    endcase
  end

  // Next output values for the current digit slot.
  always_comb begin
    w_an_nxt  = AN_OFF;
    w_bcd_nxt = BLANK_NIBBLE;
    w_dp_nxt  = 1'b1;
    if ((r_state == DRIVE) && !w_blank) begin
      w_an_nxt  = ~(4'b0001 << r_dig);
      w_bcd_nxt = w_nib;
      w_dp_nxt  = ~r_disp_dp[r_dig];
    end else begin
      w_an_nxt  = AN_OFF;
      w_bcd_nxt = BLANK_NIBBLE;
      w_dp_nxt  = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_an  <= AN_OFF;
      r_bcd <= BLANK_NIBBLE;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_nxt;
      r_bcd <= w_bcd_nxt;
      r_dp  <= w_dp_nxt;
    end
  end

  assign an      = r_an;
  assign bcd_out = r_bcd;
  assign dp      = r_dp;
  assign invalid = r_invalid;

  BCDtoSevenseg u_dec (
    .i_bcd (r_bcd),
    .o_seg (seg)
  );

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed self-checking bench for seven_seg_scanner with DIV=8, DEAD=2.
module tb_seven_seg_scanner;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  bcd_out;
  logic        invalid;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  seven_seg_scanner #(.DIV(8), .DEAD(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .load     (load),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .bcd_out  (bcd_out),
    .invalid  (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are then sampled mid-cycle on the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // Hold reset for two edges, release, and stop inside cycle 1.
  task automatic apply_reset();
    reset = 1'b1;
    load  = 1'b0;
    value = 16'h0000;
    dp_in = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      value    = 16'($urandom);
      load     = 1'($urandom);
      dp_in    = 4'($urandom);
      blank_lz = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got=%b exp=1111", an); end
      checks++; if (bcd_out !== 4'hF) begin errors++; $display("FAIL reset_bcd got=%h exp=f", bcd_out); end
      checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL reset_seg got=%b exp=1111111", seg); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", dp); end
      checks++; if (invalid !== 1'b0) begin errors++; $display("FAIL reset_invalid got=%b exp=0", invalid); end
    end
    reset = 1'b0; load = 1'b0; value = 16'h0000; dp_in = 4'b0000; blank_lz = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if (an !== ((c <= 2) ? 4'b1111 : 4'b1110)) begin
        errors++; $display("FAIL post_reset_an cyc=%0d got=%b exp=%b", c, an, (c <= 2) ? 4'b1111 : 4'b1110);
      end
      checks++;
      if (bcd_out !== ((c <= 2) ? 4'hF : 4'h0)) begin
        errors++; $display("FAIL post_reset_bcd cyc=%0d got=%h exp=%h", c, bcd_out, (c <= 2) ? 4'hF : 4'h0);
      end
      checks++;
      if (seg !== ((c <= 2) ? 7'b1111111 : 7'b0000001)) begin
        errors++; $display("FAIL post_reset_seg cyc=%0d got=%b", c, seg);
      end
    end
  endtask

  task automatic test_scan_order();
    logic [15:0] e_bcd [2] = '{16'h0000, 16'h1234};
    logic [3:0]  e_dp  [2] = '{4'b1111, 4'b1101};
    logic [6:0]  e_seg [4] = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
    logic [15:0] e_an = 16'h7BDE;
    int f, slot, off;
    logic [3:0] ea, eb;
    logic       ed;
    logic [6:0] es;
    apply_reset();
    blank_lz = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      run_to(c);
      f = (c - 1) / 32; slot = ((c - 1) % 32) / 8; off = (c - 1) % 8;
      ea = (off < 2) ? 4'hF : e_an[slot*4 +: 4];
      eb = (off < 2) ? 4'hF : e_bcd[f][slot*4 +: 4];
      ed = (off < 2) ? 1'b1 : e_dp[f][slot];
      es = (off < 2) ? 7'b1111111 : ((f == 1) ? e_seg[slot] : 7'b0000001);
      checks++; if (an !== ea) begin errors++; $display("FAIL scan_an cyc=%0d got=%b exp=%b", c, an, ea); end
      checks++; if (bcd_out !== eb) begin errors++; $display("FAIL scan_bcd cyc=%0d got=%h exp=%h", c, bcd_out, eb); end
      checks++; if (dp !== ed) begin errors++; $display("FAIL scan_dp cyc=%0d got=%b exp=%b", c, dp, ed); end
      checks++; if (seg !== es) begin errors++; $display("FAIL scan_seg cyc=%0d got=%b exp=%b", c, seg, es); end
      value = 16'h1234; dp_in = 4'b0010; load = (c == 5);
    end
    load = 1'b0;
  endtask

  task automatic test_leading_zero();
    logic [15:0] e_an  [4] = '{16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFBDE};
    logic [15:0] e_bcd [4] = '{16'hFFF0, 16'hFFF7, 16'hFFF0, 16'hF100};
    int f, slot, off;
    logic [3:0] ea, eb;
    apply_reset();
    blank_lz = 1'b1;
    for (int c = 1; c <= 128; c++) begin
      run_to(c);
      f = (c - 1) / 32; slot = ((c - 1) % 32) / 8; off = (c - 1) % 8;
      ea = (off < 2) ? 4'hF : e_an[f][slot*4 +: 4];
      eb = (off < 2) ? 4'hF : e_bcd[f][slot*4 +: 4];
      checks++; if (an !== ea) begin errors++; $display("FAIL lz_an cyc=%0d got=%b exp=%b", c, an, ea); end
      checks++; if (bcd_out !== eb) begin errors++; $display("FAIL lz_bcd cyc=%0d got=%h exp=%h", c, bcd_out, eb); end
      load  = (c == 5) || (c == 40) || (c == 70);
      value = (c == 5) ? 16'h0007 : ((c == 40) ? 16'h0000 : 16'h0100);
    end
    load = 1'b0;
    blank_lz = 1'b0;
  endtask

  task automatic test_atomic_update();
    logic [15:0] e_bcd [4] = '{16'h0000, 16'h0000, 16'h2222, 16'h5555};
    logic [15:0] e_an = 16'h7BDE;
    int f, slot, off;
    logic [3:0] ea, eb;
    apply_reset();
    blank_lz = 1'b0;
    dp_in = 4'b0000;
    for (int c = 1; c <= 104; c++) begin
      run_to(c);
      f = (c - 1) / 32; slot = ((c - 1) % 32) / 8; off = (c - 1) % 8;
      ea = (off < 2) ? 4'hF : e_an[slot*4 +: 4];
      eb = (off < 2) ? 4'hF : e_bcd[f][slot*4 +: 4];
      checks++; if (an !== ea) begin errors++; $display("FAIL atomic_an cyc=%0d got=%b exp=%b", c, an, ea); end
      checks++; if (bcd_out !== eb) begin errors++; $display("FAIL atomic_bcd cyc=%0d got=%h exp=%h", c, bcd_out, eb); end
      load  = (c == 40) || (c == 50) || (c == 95);
      value = (c == 40) ? 16'h1111 : ((c == 50) ? 16'h2222 : 16'h5555);
    end
    load = 1'b0;
  endtask

  task automatic test_invalid_nibble();
    logic [15:0] e_bcd [3] = '{16'h0000, 16'h12A4, 16'h0567};
    logic [15:0] e_an = 16'h7BDE;
    int f, slot, off;
    logic [3:0] ea, eb;
    logic       ei;
    apply_reset();
    blank_lz = 1'b0;
    for (int c = 1; c <= 72; c++) begin
      run_to(c);
      f = (c - 1) / 32; slot = ((c - 1) % 32) / 8; off = (c - 1) % 8;
      ea = (off < 2) ? 4'hF : e_an[slot*4 +: 4];
      eb = (off < 2) ? 4'hF : e_bcd[f][slot*4 +: 4];
      ei = (c >= 32) && (c <= 63);
      checks++; if (an !== ea) begin errors++; $display("FAIL inv_an cyc=%0d got=%b exp=%b", c, an, ea); end
      checks++; if (bcd_out !== eb) begin errors++; $display("FAIL inv_bcd cyc=%0d got=%h exp=%h", c, bcd_out, eb); end
      checks++; if (invalid !== ei) begin errors++; $display("FAIL inv_flag cyc=%0d got=%b exp=%b", c, invalid, ei); end
      if ((f == 1) && (slot == 1) && (off >= 2)) begin
        checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL inv_seg_dark cyc=%0d got=%b exp=1111111", c, seg); end
      end
      if ((f == 1) && (slot == 0) && (off >= 2)) begin
        checks++; if (seg !== 7'b1001100) begin errors++; $display("FAIL inv_seg_four cyc=%0d got=%b exp=1001100", c, seg); end
      end
      load  = (c == 5) || (c == 50);
      value = (c == 5) ? 16'h12A4 : 16'h0567;
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    blank_lz = 1'b0;
    for (int c = 1; c <= 53; c++) begin
      run_to(c);
      load = (c == 5); value = 16'h1234; dp_in = 4'b0100;
    end
    load = 1'b0;
    checks++; if (an !== 4'b1011) begin errors++; $display("FAIL mid_pre_an got=%b exp=1011", an); end
    checks++; if (bcd_out !== 4'h2) begin errors++; $display("FAIL mid_pre_bcd got=%h exp=2", bcd_out); end
    checks++; if (dp !== 1'b0) begin errors++; $display("FAIL mid_pre_dp got=%b exp=0", dp); end
    reset = 1'b1;
    tick();
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL mid_rst_an got=%b exp=1111", an); end
    checks++; if (bcd_out !== 4'hF) begin errors++; $display("FAIL mid_rst_bcd got=%h exp=f", bcd_out); end
    checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL mid_rst_seg got=%b exp=1111111", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL mid_rst_dp got=%b exp=1", dp); end
    checks++; if (invalid !== 1'b0) begin errors++; $display("FAIL mid_rst_invalid got=%b exp=0", invalid); end
    reset = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      run_to(c);
      checks++;
      if (an !== ((((c - 1) % 8) < 2) ? 4'hF : ((((c - 1) % 32) < 8) ? 4'b1110 :
                  ((((c - 1) % 32) < 16) ? 4'b1101 : ((((c - 1) % 32) < 24) ? 4'b1011 : 4'b0111))))) begin
        errors++; $display("FAIL mid_resume_an cyc=%0d got=%b", c, an);
      end
      checks++;
      if (bcd_out !== ((((c - 1) % 8) < 2) ? 4'hF : 4'h0)) begin
        errors++; $display("FAIL mid_resume_bcd cyc=%0d got=%h", c, bcd_out);
      end
    end
  endtask

  initial begin
    reset = 1'b1; value = 16'h0000; load = 1'b0; dp_in = 4'b0000; blank_lz = 1'b0;
    test_reset();
    test_scan_order();
    test_leading_zero();
    test_atomic_update();
    test_invalid_nibble();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
